// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core: machine word, fetch-stage
// state encoding and the default sequential fetch increment.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HELD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t FETCH_STRIDE_C = 32'd4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register for the fetch stage. A redirect loads the
// supplied target unmodified; an advance steps by the fetch stride with
// natural 32-bit wrap. Neither asserted means the PC holds.
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0,
  parameter word_t STRIDE   = FETCH_STRIDE_C
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  advance,
  input  logic  redirect,
  input  word_t target,
  output word_t pc,
  output word_t pc_plus
);

  assign pc_plus = pc + STRIDE;

  // PC update: redirect target has priority over the sequential step.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= PC_RESET;
    end else if (redirect) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc_plus;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the icache request and
// hands the fetched word plus PC+stride to the IF/ID latch. A one-entry
// hold buffer parks an icache hit that arrives while the hazard unit is
// stalling, so the word is not refetched.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET     = 32'h0,
  parameter word_t FETCH_STRIDE = FETCH_STRIDE_C
`ifdef FETCH_PERF_EN
  ,
  parameter int    CNT_W        = 32
`endif
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              h_pcen,
  input  logic              ifid_pause,
  input  logic              branch_take,
  input  logic [31:0]       branch_target,
  input  logic              jump_take,
  input  logic [31:0]       jump_target,
  input  logic              halt,
  input  logic              ihit,
  input  logic [31:0]       imemload,
  output logic              imemREN,
  output logic [31:0]       imemaddr,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_npc,
`ifdef FETCH_PERF_EN
  output logic [CNT_W-1:0]  perf_fetch_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt,
`endif
  output logic              fetch_halted
);

  fetch_state_t state, next_state;
  word_t        pc, pc_plus, target;
  logic         stall, redirect;
  logic         pc_advance, pc_redirect;
  logic         hold_load, hold_clear;
  logic         hold_valid;
  word_t        hold_instr;

  assign stall    = !h_pcen | ifid_pause;
  assign redirect = branch_take | jump_take;
  assign target   = branch_take ? branch_target : jump_target;

  pc_reg #(
    .PC_RESET (PC_RESET),
    .STRIDE   (FETCH_STRIDE)
  ) u_pc_reg (
    .CLK      (CLK),
    .nRST     (nRST),
    .advance  (pc_advance),
    .redirect (pc_redirect),
    .target   (target),
    .pc       (pc),
    .pc_plus  (pc_plus)
  );

  assign imemaddr     = pc;
  assign if_npc       = pc_plus;
  assign fetch_halted = (state == HALTED);

  // State register; HALTED is only left through reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Hold buffer: parks a stalled hit until the stall clears or a redirect drops it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold_valid <= 1'b0;
      hold_instr <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_instr <= imemload;
    end else if (hold_clear) begin
      hold_valid <= 1'b0;
    end
  end

  // Next-state and IF/ID outputs, priority halt > redirect > stall > delivery.
  always_comb begin
    next_state  = state;
    pc_advance  = 1'b0;
    pc_redirect = 1'b0;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    imemREN     = 1'b0;
    if_valid    = 1'b0;
    if_instr    = '0;
    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (halt) begin
          next_state = HALTED;
        end else if (redirect) begin
          pc_redirect = 1'b1;
        end else if (ihit && stall) begin
          hold_load  = 1'b1;
          next_state = HELD;
        end else if (ihit) begin
          if_valid   = 1'b1;
          if_instr   = imemload;
          pc_advance = 1'b1;
        end
      end
      HELD: begin
        if (halt) begin
          next_state = HALTED;
        end else if (redirect) begin
          pc_redirect = 1'b1;
          hold_clear  = 1'b1;
          next_state  = FETCH;
        end else if (!stall) begin
          if_valid    = hold_valid;
          if_instr    = hold_instr;
          pc_advance  = 1'b1;
          hold_clear  = 1'b1;
          next_state  = FETCH;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counters, frozen once fetch has halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (state != HALTED) begin
      if (if_valid && (perf_fetch_cnt != '1)) begin
        perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(1);
      end
      if (stall && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Directed stimulus pushes each expected IF/ID
// delivery {instr, npc} into a scoreboard queue; an independent monitor
// pops and compares whenever the DUT raises if_valid. Control outputs
// (imemREN, imemaddr, fetch_halted) are checked directly after each step.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        h_pcen;
  logic        ifid_pause;
  logic        branch_take;
  word_t       branch_target;
  logic        jump_take;
  word_t       jump_target;
  logic        halt;
  logic        ihit;
  word_t       imemload;
  logic        imemREN;
  word_t       imemaddr;
  logic        if_valid;
  word_t       if_instr;
  word_t       if_npc;
  logic        fetch_halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int          checks = 0;
  int          fails  = 0;
  logic [63:0] sb_q[$];

  fetch_unit dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .h_pcen        (h_pcen),
    .ifid_pause    (ifid_pause),
    .branch_take   (branch_take),
    .branch_target (branch_target),
    .jump_take     (jump_take),
    .jump_target   (jump_target),
    .halt          (halt),
    .ihit          (ihit),
    .imemload      (imemload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_npc        (if_npc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .fetch_halted  (fetch_halted)
  );

  // Free-running core clock, posedge at 5, 15, 25 ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the posedge, queue any expected
  // delivery, then settle at the following negedge for sampling.
  task automatic applyStimulus(input logic pcen, input logic pause,
                               input logic bt, input word_t btgt,
                               input logic jt, input word_t jtgt,
                               input logic hlt, input logic hit, input word_t load,
                               input logic exp_v, input word_t exp_instr, input word_t exp_npc);
    @(posedge CLK);
    #1;
    h_pcen        = pcen;
    ifid_pause    = pause;
    branch_take   = bt;
    branch_target = btgt;
    jump_take     = jt;
    jump_target   = jtgt;
    halt          = hlt;
    ihit          = hit;
    imemload      = load;
    if (exp_v) sb_q.push_back({exp_instr, exp_npc});
    @(negedge CLK);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: every IF/ID delivery must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && if_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_fetch: got instr 0x%08h npc 0x%08h, expected no delivery at %0t",
                 if_instr, if_npc, $time);
      end else begin
        logic [63:0] exp_item;
        exp_item = sb_q.pop_front();
        if ({if_instr, if_npc} !== exp_item) begin
          fails++;
          $display("[TB] FAIL fetch_data: got instr 0x%08h npc 0x%08h, expected instr 0x%08h npc 0x%08h at %0t",
                   if_instr, if_npc, exp_item[63:32], exp_item[31:0], $time);
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    nRST = 1'b0; h_pcen = 1'b1; ifid_pause = 1'b0;
    branch_take = 1'b0; branch_target = '0; jump_take = 1'b0; jump_target = '0;
    halt = 1'b0; ihit = 1'b0; imemload = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_imemaddr", imemaddr, 32'h0);
    checkOutput("rst_imemREN", word_t'(imemREN), 32'h1);
    checkOutput("rst_if_valid", word_t'(if_valid), 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);
    checkOutput("rst_if_npc", if_npc, 32'h4);
    checkOutput("rst_halted", word_t'(fetch_halted), 32'h0);
    nRST = 1'b1;

    // Back-to-back hits.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h20010001, 1, 32'h20010001, 32'h4);
    checkOutput("seq_addr0", imemaddr, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h20020002, 1, 32'h20020002, 32'h8);
    checkOutput("seq_addr1", imemaddr, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h00221820, 1, 32'h00221820, 32'hC);
    checkOutput("seq_addr2", imemaddr, 32'h8);

    // Hit during a two-cycle stall is parked, then delivered.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 32'h8C430004, 0, 0, 0);
    checkOutput("stall_hit_ren", word_t'(imemREN), 32'h1);
    checkOutput("stall_hit_valid", word_t'(if_valid), 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("held_ren", word_t'(imemREN), 32'h0);
    checkOutput("held_pc", imemaddr, 32'hC);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch", perf_fetch_cnt, 32'd3);
`endif
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8C430004, 32'h10);
    checkOutput("release_pc", imemaddr, 32'hC);
`ifdef FETCH_PERF_EN
    checkOutput("perf_stall", perf_stall_cnt, 32'd2);
`endif
    idleCycle();
    checkOutput("after_release_pc", imemaddr, 32'h10);
    checkOutput("after_release_ren", word_t'(imemREN), 32'h1);

    // Branch while holding drops the parked word.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 32'hAAAA0001, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h40, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("held_br_ren", word_t'(imemREN), 32'h0);
    idleCycle();
    checkOutput("held_br_pc", imemaddr, 32'h40);
    checkOutput("held_br_ren_next", word_t'(imemREN), 32'h1);

    // Branch and jump together with a hit: branch target wins, hit discarded.
    applyStimulus(1, 0, 1, 32'h100, 1, 32'h200, 0, 1, 32'hBBBB0002, 0, 0, 0);
    checkOutput("both_valid", word_t'(if_valid), 32'h0);
    idleCycle();
    checkOutput("both_pc", imemaddr, 32'h100);

    // Jump alone to the top word, then fetch across the 32-bit wrap.
    applyStimulus(1, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 1, 32'hCCCC0003, 0, 0, 0);
    idleCycle();
    checkOutput("jump_pc", imemaddr, 32'hFFFFFFFC);
    checkOutput("wrap_npc", if_npc, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000000C, 1, 32'h0000000C, 32'h0);
    idleCycle();
    checkOutput("wrap_pc", imemaddr, 32'h0);

    // Miss at 0x44, then asynchronous reset mid-cycle.
    applyStimulus(1, 0, 0, 0, 1, 32'h44, 0, 0, 32'h0, 0, 0, 0);
    idleCycle();
    checkOutput("miss_pc", imemaddr, 32'h44);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("async_rst_pc", imemaddr, 32'h0);
    checkOutput("async_rst_npc", if_npc, 32'h4);
    #1;
    nRST = 1'b1;

    // Halt: fetching stops for good.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 32'hDDDD0004, 0, 0, 0);
    checkOutput("halt_cycle_valid", word_t'(if_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'hEEEE0005, 0, 0, 0);
      checkOutput("halted_flag", word_t'(fetch_halted), 32'h1);
      checkOutput("halted_ren", word_t'(imemREN), 32'h0);
      checkOutput("halted_pc", imemaddr, 32'h0);
    end

    checkOutput("sb_empty", word_t'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
